data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
- Shares the single-port Data_Memory (A, WD, WE, RD, CLK) between two requesters.
- Port 0 is the core load/store unit; port 1 is a loader/debug/DMA master.
- Each cycle it grants at most one access using a hold-limited ownership FSM, then drives the memory port from the winner.
- Read data is registered and returned to the winning port one cycle after its grant.

Parameters:
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, data width
- MAX_HOLD, 4, maximum consecutive grants to one port while the other is requesting (>=1)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- P0_REQ  in  1  port 0 access request; held with payload until P0_GNT=1
- P0_WE  in  1  port 0: 1=write, 0=read
- P0_A  in  ADDR_W  port 0 address
- P0_WD  in  DATA_W  port 0 write data
- P0_GNT  out  1  port 0 access performed this cycle
- P0_RVALID  out  1  port 0 read data valid
- P0_RD  out  DATA_W  port 0 read data
- P1_REQ, P1_WE, P1_A, P1_WD, P1_GNT, P1_RVALID, P1_RD: same as port 0, for port 1
- MEM_A  out  ADDR_W  to Data_Memory A
- MEM_WD  out  DATA_W  to Data_Memory WD
- MEM_WE  out  1  to Data_Memory WE
- MEM_RD  in  DATA_W  from Data_Memory RD (combinational read)

Behaviour:
- Reset, asynchronous:
  - state=IDLE, hold count cnt=0.
  - P0_RVALID=P1_RVALID=0, P0_RD=P1_RD=0.
  - While RST=1: both GNT=0 and MEM_WE=0, so no write occurs.
- Grant and memory drive:
  - GNT is combinational from REQ, state and cnt; at most one GNT high.
  - MEM_A, MEM_WD and MEM_WE come from the granted port; MEM_WE = granted WE.
  - No grant: MEM_WE=0, MEM_A and MEM_WD hold port 0 values (don't-care).
- Writes: committed by Data_Memory at the edge ending the grant cycle. GNT is the completion; no RVALID is produced.
- Reads:
  - MEM_RD is captured at the edge ending the grant cycle.
  - The next cycle, the winning port sees RVALID=1 and RD = captured data. Latency is 1 cycle.
  - RVALID lasts one cycle unless a back-to-back read is granted.
  - RD holds its last value when RVALID=0.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE:
    - P0_REQ: grant 0, go to OWN0, cnt=1.
    - Else P1_REQ: grant 1, go to OWN1, cnt=1.
    - Else: stay IDLE.
    - Simultaneous requests: port 0 wins.
  - OWN0:
    - P0_REQ and (cnt<MAX_HOLD or !P1_REQ): grant 0, cnt=min(cnt+1, MAX_HOLD).
    - Else P1_REQ: grant 1, go to OWN1, cnt=1.
    - Else: go to IDLE, cnt=0.
  - OWN1: symmetric to OWN0.
- Starvation bound: a requesting port waits at most MAX_HOLD cycles.
- cnt saturates at MAX_HOLD. When cnt has saturated and the other port starts requesting, ownership switches on that same cycle.
- Hazards:
  - Write then read to the same address by different ports in consecutive grants: the read returns the new data.
  - Same-cycle conflicting requests: serialized by the grant order above.
- Reset asserted mid-operation: a pending RVALID is cleared and not re-issued. The requester must re-request after reset.

Decomposition:
- Package data_mem_arb_pkg:
  - state encoding IDLE=2'b00, OWN0=2'b01, OWN1=2'b10
  - port index constants PORT0=0, PORT1=1
  - hold counter width = clog2(MAX_HOLD+1)
- Sub-module dmem_arb_fsm: state, cnt and the grant/next-state logic, with inputs REQ[1:0] and outputs GNT[1:0].
- Top level holds the memory mux and read-return registers.

Test Plan:
- RST=1 with both REQ=1 and P0_WE=1 -> GNT=00, MEM_WE=0, RVALID=0, memory unchanged. Release RST -> P0_GNT=1 on the first cycle.
- P0 write A=0x10, WD=0xDEADBEEF; then P0 read A=0x10 -> both granted immediately. Cycle after the read grant: P0_RVALID=1, P0_RD=0xDEADBEEF, P1_RVALID=0.
- Both REQ held continuously, MAX_HOLD=4 -> grant sequence 0,0,0,0,1,1,1,1,0,...; neither port waits more than 4 cycles.
- P1 alone reads A=0x04 (preloaded 0x000000FB) from OWN0 -> P1_GNT=1 the same cycle, state becomes OWN1, next cycle P1_RD=0x000000FB.
- From IDLE, same cycle: P0 writes 0x20 with 0x12345678 and P1 reads 0x20 -> P0 granted first, P1 granted next cycle, then P1_RD=0x12345678.
- Read granted to P1, RST pulsed in the following cycle -> P1_RVALID=0, P1_RD=0. After release, state is IDLE.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the two-port Data_Memory arbiter.
//   arb_state_e : ownership FSM state encoding
//   PORT0/PORT1 : requester indices into the REQ/GNT vectors
//   hold_cnt_w  : width of the consecutive-grant counter for a given MAX_HOLD
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  localparam int unsigned PORT0     = 0;
  localparam int unsigned PORT1     = 1;
  localparam int unsigned NUM_PORTS = 2;

  // Counter must represent 0..MAX_HOLD inclusive.
  function automatic int unsigned hold_cnt_w(input int unsigned max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_fsm.sv
// Hold-limited ownership FSM for the Data_Memory arbiter.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high; forces gnt_o to 0 while high
//   req_i  : request vector, bit PORT0 / PORT1
//   gnt_o  : one-hot (or zero) grant, combinational from req_i, state and count
module dmem_arb_fsm
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  localparam int unsigned       CNT_W   = hold_cnt_w(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt;
  logic [CNT_W-1:0]       cnt_inc;

  // Saturating increment of the consecutive-grant count.
  assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  // State and hold-count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant and next-state selection; the owner keeps the port until its
  // run reaches MAX_HOLD while the other side is waiting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = '0;
    unique case (state_q)
      IDLE: begin
        if (req_i[PORT0]) begin
          gnt[PORT0] = 1'b1;
          state_d    = OWN0;
          cnt_d      = CNT_ONE;
        end else if (req_i[PORT1]) begin
          gnt[PORT1] = 1'b1;
          state_d    = OWN1;
          cnt_d      = CNT_ONE;
        end
      end
      OWN0: begin
        if (req_i[PORT0] && ((cnt_q < CNT_MAX) || !req_i[PORT1])) begin
          gnt[PORT0] = 1'b1;
          cnt_d      = cnt_inc;
        end else if (req_i[PORT1]) begin
          gnt[PORT1] = 1'b1;
          state_d    = OWN1;
          cnt_d      = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        if (req_i[PORT1] && ((cnt_q < CNT_MAX) || !req_i[PORT0])) begin
          gnt[PORT1] = 1'b1;
          cnt_d      = cnt_inc;
        end else if (req_i[PORT0]) begin
          gnt[PORT0] = 1'b1;
          state_d    = OWN0;
          cnt_d      = CNT_ONE;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // No access may be performed while reset is held.
  assign gnt_o = rst_i ? '0 : gnt;

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port Data_Memory between the core LSU (port 0) and a
// loader/debug/DMA master (port 1).
// Ports:
//   CLK, RST                      : clock (rising edge), async active-high reset
//   Pn_REQ/WE/A/WD                : request and payload, held until Pn_GNT
//   Pn_GNT                        : access performed this cycle (combinational)
//   Pn_RVALID/Pn_RD               : read return, one cycle after the read grant
//   MEM_A/MEM_WD/MEM_WE, MEM_RD   : Data_Memory port (combinational read)
module data_memory_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              P0_REQ,
  input  logic              P0_WE,
  input  logic [ADDR_W-1:0] P0_A,
  input  logic [DATA_W-1:0] P0_WD,
  output logic              P0_GNT,
  output logic              P0_RVALID,
  output logic [DATA_W-1:0] P0_RD,
  input  logic              P1_REQ,
  input  logic              P1_WE,
  input  logic [ADDR_W-1:0] P1_A,
  input  logic [DATA_W-1:0] P1_WD,
  output logic              P1_GNT,
  output logic              P1_RVALID,
  output logic [DATA_W-1:0] P1_RD,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [DATA_W-1:0] MEM_WD,
  output logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_RD
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] rd_grant;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [DATA_W-1:0]    rd0_q, rd1_q;

  assign req = {P1_REQ, P0_REQ};

  dmem_arb_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_fsm (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign P0_GNT = gnt[PORT0];
  assign P1_GNT = gnt[PORT1];

  // Memory port mux; port 0 payload is parked on the bus when idle.
  always_comb begin
    MEM_A  = P0_A;
    MEM_WD = P0_WD;
    MEM_WE = 1'b0;
    if (gnt[PORT1]) begin
      MEM_A  = P1_A;
      MEM_WD = P1_WD;
      MEM_WE = P1_WE;
    end else if (gnt[PORT0]) begin
      MEM_WE = P0_WE;
    end
  end

  assign rd_grant[PORT0] = gnt[PORT0] & ~P0_WE;
  assign rd_grant[PORT1] = gnt[PORT1] & ~P1_WE;

  // Read-return registers: capture MEM_RD at the end of a read grant,
  // RD holds its last value otherwise.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid_q <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      rvalid_q <= rd_grant;
      if (rd_grant[PORT0]) rd0_q <= MEM_RD;
      if (rd_grant[PORT1]) rd1_q <= MEM_RD;
    end
  end

  assign P0_RVALID = rvalid_q[PORT0];
  assign P1_RVALID = rvalid_q[PORT1];
  assign P0_RD     = rd0_q;
  assign P1_RD     = rd1_q;

endmodule
